// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - round-robin arbiter sharing one line-wide memory port between I-cache and D-cache
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   i_read, i_address                I-cache line read request (held until i_resp)
//   i_rdata, i_resp                  line data to I-cache, one-cycle completion pulse
//   d_read, d_write, d_address,      D-cache line read/write request (held until d_resp)
//   d_wdata
//   d_rdata, d_resp                  line data to D-cache, one-cycle completion pulse
//   pmem_read, pmem_write,           command to physical memory (registered)
//   pmem_address, pmem_wdata
//   pmem_rdata, pmem_resp            memory read data and completion pulse

module cache_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t            state;
    logic              last_grant;   // 0 = I-cache, 1 = D-cache
    logic [ADDR_W-1:0] lat_addr;
    logic [LINE_W-1:0] lat_wdata;

    logic i_req;
    logic d_req;
    logic grant_d;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // D wins when it is alone, or when both ask and I had the previous grant.
    assign grant_d = d_req & (~i_req | ~last_grant);

    // pmem_read/pmem_write are the latched operation; they are loaded on the
    // grant edge and cleared on the completing edge, so they double as the
    // command registers and stay stable for the whole transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state      <= SERVE_D;
                        last_grant <= 1'b1;
                        lat_addr   <= d_address;
                        lat_wdata  <= d_wdata;
                        // A simultaneous read and write is treated as a write.
                        pmem_write <= d_write;
                        pmem_read  <= ~d_write;
                    end else if (i_req) begin
                        state      <= SERVE_I;
                        last_grant <= 1'b0;
                        lat_addr   <= i_address;
                        pmem_write <= 1'b0;
                        pmem_read  <= 1'b1;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        state      <= IDLE;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    pmem_read  <= 1'b0;
                    pmem_write <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_address = lat_addr;
    assign pmem_wdata   = lat_wdata;

    // Completion is forwarded combinationally only to the granted side;
    // a response arriving in IDLE goes nowhere.
    assign i_resp = (state == SERVE_I) & pmem_resp;
    assign d_resp = (state == SERVE_D) & pmem_resp;

    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter LINE_W, default 256, cacheline width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_read  input  1  I-cache line read request, held until i_resp.
REQ-006 SHALL have port i_address  input  ADDR_W  I-cache line address.
REQ-007 SHALL have port i_rdata  output  LINE_W  line returned to I-cache.
REQ-008 SHALL have port i_resp  output  1  one-cycle completion pulse to I-cache.
REQ-009 SHALL have ports d_read, d_write  input  1 each  D-cache line read/write requests, held until d_resp.
REQ-010 SHALL have ports d_address  input  ADDR_W, and d_wdata  input  LINE_W  D-cache address and write line.
REQ-011 SHALL have ports d_rdata  output  LINE_W, and d_resp  output  1  D-cache read data and completion pulse.
REQ-012 SHALL have ports pmem_read, pmem_write  output  1 each  physical memory commands.
REQ-013 SHALL have ports pmem_address  output  ADDR_W, and pmem_wdata  output  LINE_W  to memory.
REQ-014 SHALL have ports pmem_rdata  input  LINE_W, and pmem_resp  input  1  memory data and completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, SERVE_I, SERVE_D.
REQ-016 SHALL keep register last_grant (0=I, 1=D).
REQ-017 In IDLE with only the I-cache requesting, next state SHALL be SERVE_I.
REQ-018 In IDLE with only the D-cache requesting (d_read or d_write), next state SHALL be SERVE_D.
REQ-019 In IDLE with both requesting, SHALL grant the requester not equal to last_grant (round-robin).
REQ-020 On the grant edge, SHALL latch the winner's address, its d_wdata (D only) and its operation (read/write) into internal registers, and update last_grant.
REQ-021 In SERVE_I, SHALL drive pmem_read=1, pmem_write=0, and pmem_address from the latched register.
REQ-022 In SERVE_D, SHALL drive exactly one of pmem_read/pmem_write per the latched operation, with pmem_address and pmem_wdata from the latched registers.
REQ-023 In IDLE, SHALL drive pmem_read=pmem_write=0.
REQ-024 In SERVE_x, SHALL drive x_resp=pmem_resp combinationally; the non-granted resp SHALL be 0.
REQ-025 SHALL pass pmem_rdata through to i_rdata and d_rdata unconditionally; data is valid only with the matching resp.
REQ-026 On pmem_resp in SERVE_x, next state SHALL be IDLE; exactly one bubble cycle follows every transaction.
REQ-027 Latency SHALL be: request visible in IDLE at cycle N -> pmem command asserted at cycle N+1 -> resp in the same cycle as pmem_resp.
REQ-028 SHALL hold the latched command stable while waiting, however many cycles pmem_resp takes.
REQ-029 If d_read and d_write are both asserted at grant, SHALL latch a write.
REQ-030 A requester dropping its request mid-transaction SHALL NOT abort it; the arbiter completes it and pulses resp.
REQ-031 pmem_resp in IDLE SHALL be ignored: no resp pulse and no state change.
REQ-032 A requester SHALL never be granted twice in a row while the other requests at the IDLE decision point (no starvation).

Reset
REQ-033 While rst=1, SHALL force state=IDLE, last_grant=1 (first contested grant goes to I), and latched address/wdata/operation=0, immediately and independent of clk.
REQ-034 During and directly after reset, all outputs SHALL be 0 except rdata passthroughs; pmem_read/pmem_write SHALL fall in the same cycle rst rises.
REQ-035 Reset mid-transaction SHALL drop the transaction silently: no resp pulse for it, and a later pmem_resp SHALL be ignored per REQ-031.

Verification
REQ-036 I-cache only: i_read=1, i_address=0x0000_1000, pmem_resp after 3 cycles -> pmem_read=1 with pmem_address=0x1000 from cycle 1; i_resp pulses once with i_rdata=pmem_rdata; IDLE for one cycle afterwards.
REQ-037 Simultaneous requests after reset: i_read and d_write (0x2000, wdata=all 0xA5) -> I served first, then D with pmem_write=1, pmem_address=0x2000, and the correct wdata.
REQ-038 Continuous contention, both requesting for 6 transactions -> grants alternate I,D,I,D,I,D.
REQ-039 D-cache address changes from 0x3000 to 0x4000 while waiting -> pmem_address stays 0x3000 until resp.
REQ-040 Assert rst two cycles into SERVE_D, then pulse pmem_resp after release -> pmem_write drops immediately, no d_resp, state IDLE.
REQ-041 d_read=d_write=1 -> pmem_write=1 and pmem_read=0 for the whole transaction.
